// File: rtl/d_npc_ctrl.sv
// d_npc_ctrl: next-PC / branch resolution with one delay slot; `NPC_STAT_EN adds saturating branch counters.
module d_npc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       d_pc,
    input  logic [15:0]       d_imm16,
    input  logic [25:0]       d_imm26,
    input  logic [31:0]       d_rs_val,
    input  logic [3:0]        br_type,
    input  logic [1:0]        cmp_ab,
    input  logic [1:0]        cmp_a0,
    output logic [31:0]       f_pc,
    output logic              br_taken,
    output logic [31:0]       link_pc,
    output logic              d_in_ds,
`ifdef NPC_STAT_EN
    output logic [CNT_W-1:0]  br_cnt_taken,
    output logic [CNT_W-1:0]  br_cnt_ntaken,
`endif
    output logic              npc_err
);
    logic [31:0] d_pc4, target;
    logic        is_cond, is_xfer, inv;
    assign d_pc4   = d_pc + 32'd4;
    assign link_pc = d_pc + 32'd8;
    assign is_cond = br_type >= 4'd1 && br_type <= 4'd6;
    assign is_xfer = br_type >= 4'd1 && br_type <= 4'd10;
    assign inv     = ((br_type == 4'd1 || br_type == 4'd2) && cmp_ab == 2'b11) ||
                     (br_type >= 4'd3 && br_type <= 4'd6 && cmp_a0 == 2'b11);
    assign target  = (br_type == 4'd9 || br_type == 4'd10) ? d_rs_val :
                     (br_type == 4'd7 || br_type == 4'd8)  ? {d_pc4[31:28], d_imm26, 2'b00} :
                     d_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    // A code of 11 matches none of the arms below, so invalid compares fall through as not taken
    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            4'd1:                      br_taken = cmp_ab == 2'b00;
            4'd2:                      br_taken = cmp_ab == 2'b01 || cmp_ab == 2'b10;
            4'd3:                      br_taken = cmp_a0 == 2'b00 || cmp_a0 == 2'b10;
            4'd4:                      br_taken = cmp_a0 == 2'b01;
            4'd5:                      br_taken = cmp_a0 == 2'b10;
            4'd6:                      br_taken = cmp_a0 == 2'b00 || cmp_a0 == 2'b01;
            4'd7, 4'd8, 4'd9, 4'd10:   br_taken = 1'b1;
            default:                   br_taken = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            f_pc    <= RESET_PC;
            d_in_ds <= 1'b0;
            npc_err <= 1'b0;
        end else if (!stall) begin
            f_pc    <= br_taken ? target : f_pc + 32'd4;
            d_in_ds <= is_xfer;
            if (inv || (br_taken && target[1:0] != 2'b00))
                npc_err <= 1'b1;
        end
    end
`ifdef NPC_STAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            br_cnt_taken  <= '0;
            br_cnt_ntaken <= '0;
        end else if (!stall && is_cond) begin
            if (br_taken && !(&br_cnt_taken))
                br_cnt_taken <= br_cnt_taken + CNT_W'(1);
            if (!br_taken && !(&br_cnt_ntaken))
                br_cnt_ntaken <= br_cnt_ntaken + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_d_npc_ctrl.sv
// tb_d_npc_ctrl: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_d_npc_ctrl;
    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] d_pc, d_rs_val, f_pc, link_pc;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [3:0]  br_type;
    logic [1:0]  cmp_ab, cmp_a0;
    logic        br_taken, d_in_ds, npc_err;
`ifdef NPC_STAT_EN
    logic [31:0] br_cnt_taken, br_cnt_ntaken;
`endif
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        int          row;
        logic [31:0] fpc, link, ct, cn;
        logic        ds, err, tk;
    } exp_t;
    exp_t q[$];

    d_npc_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .d_pc(d_pc), .d_imm16(d_imm16),
        .d_imm26(d_imm26), .d_rs_val(d_rs_val), .br_type(br_type), .cmp_ab(cmp_ab),
        .cmp_a0(cmp_a0), .f_pc(f_pc), .br_taken(br_taken), .link_pc(link_pc),
        .d_in_ds(d_in_ds),
`ifdef NPC_STAT_EN
        .br_cnt_taken(br_cnt_taken), .br_cnt_ntaken(br_cnt_ntaken),
`endif
        .npc_err(npc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input int row, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row%0d %s: got %h expected %h", row, nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.row, "f_pc", f_pc, e.fpc);
            check(e.row, "d_in_ds", {31'd0, d_in_ds}, {31'd0, e.ds});
            check(e.row, "npc_err", {31'd0, npc_err}, {31'd0, e.err});
            check(e.row, "br_taken", {31'd0, br_taken}, {31'd0, e.tk});
            check(e.row, "link_pc", link_pc, e.link);
`ifdef NPC_STAT_EN
            check(e.row, "br_cnt_taken", br_cnt_taken, e.ct);
            check(e.row, "br_cnt_ntaken", br_cnt_ntaken, e.cn);
`endif
        end
    end

    // Inputs for one cycle plus what the monitor must see mid-cycle: state left by
    // earlier edges, and combinational outputs for these inputs.
    task automatic cyc(input int row, input bit chk, input logic rst, input logic stl,
                       input logic [3:0] bt, input logic [31:0] pc, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs, input logic [1:0] ab,
                       input logic [1:0] a0, input logic [31:0] efpc, input logic eds,
                       input logic eerr, input logic etk, input logic [31:0] elink,
                       input logic [31:0] ect, input logic [31:0] ecn);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; stall = stl; br_type = bt; d_pc = pc; d_imm16 = i16;
        d_imm26 = i26; d_rs_val = rs; cmp_ab = ab; cmp_a0 = a0;
        e.row = row; e.fpc = efpc; e.ds = eds; e.err = eerr; e.tk = etk;
        e.link = elink; e.ct = ect; e.cn = ecn;
        if (chk) q.push_back(e);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; br_type = 4'd0; d_pc = '0; d_imm16 = '0;
        d_imm26 = '0; d_rs_val = '0; cmp_ab = 2'b00; cmp_a0 = 2'b00;
        //   row chk rst stl bt    d_pc          imm16     imm26       rs_val        ab     a0      f_pc          ds    err   tk    link          ct  cn
        cyc( 0, 0, 0, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8,        0, 0);
        cyc( 1, 1, 0, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h3000,     1'b0, 1'b0, 1'b0, 32'h8,        0, 0);
        cyc( 2, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h3000,     1'b0, 1'b0, 1'b0, 32'h8,        0, 0);
        cyc( 3, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h3004,     1'b0, 1'b0, 1'b0, 32'h8,        0, 0);
        cyc( 4, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h3008,     1'b0, 1'b0, 1'b0, 32'h8,        0, 0);
        cyc( 5, 1, 1, 0, 4'd1,  32'h3010,     16'hFFFE, 26'h0,       32'h0,        2'b00, 2'b00, 32'h300C,     1'b0, 1'b0, 1'b1, 32'h3018,     0, 0);
        cyc( 6, 1, 1, 0, 4'd0,  32'h3014,     16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h300C,     1'b1, 1'b0, 1'b0, 32'h301C,     1, 0);
        cyc( 7, 1, 1, 1, 4'd4,  32'h3020,     16'h0010, 26'h0,       32'h0,        2'b00, 2'b10, 32'h3010,     1'b0, 1'b0, 1'b0, 32'h3028,     1, 0);
        cyc( 8, 1, 1, 0, 4'd4,  32'h3020,     16'h0010, 26'h0,       32'h0,        2'b00, 2'b10, 32'h3010,     1'b0, 1'b0, 1'b0, 32'h3028,     1, 0);
        cyc( 9, 1, 1, 0, 4'd0,  32'h3024,     16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h3014,     1'b1, 1'b0, 1'b0, 32'h302C,     1, 1);
        cyc(10, 1, 1, 0, 4'd8,  32'h3040,     16'h0,    26'h0000C10, 32'h0,        2'b00, 2'b00, 32'h3018,     1'b0, 1'b0, 1'b1, 32'h3048,     1, 1);
        cyc(11, 1, 1, 0, 4'd9,  32'h3044,     16'h0,    26'h0,       32'h3042,     2'b00, 2'b00, 32'h3040,     1'b1, 1'b0, 1'b1, 32'h304C,     1, 1);
        cyc(12, 1, 1, 0, 4'd9,  32'h3048,     16'h0,    26'h0,       32'hFFFFFFFC, 2'b00, 2'b00, 32'h3042,     1'b1, 1'b1, 1'b1, 32'h3050,     1, 1);
        cyc(13, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 32'h8,        1, 1);
        cyc(14, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h8,        1, 1);
        cyc(15, 1, 0, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h4,        1'b0, 1'b1, 1'b0, 32'h8,        1, 1);
        cyc(16, 1, 1, 0, 4'd1,  32'h3100,     16'h0010, 26'h0,       32'h0,        2'b11, 2'b00, 32'h3000,     1'b0, 1'b0, 1'b0, 32'h3108,     0, 0);
        cyc(17, 1, 1, 0, 4'd2,  32'h3104,     16'h0004, 26'h0,       32'h0,        2'b01, 2'b00, 32'h3004,     1'b1, 1'b1, 1'b1, 32'h310C,     0, 1);
        cyc(18, 1, 1, 0, 4'd2,  32'h3104,     16'h0004, 26'h0,       32'h0,        2'b10, 2'b00, 32'h3118,     1'b1, 1'b1, 1'b1, 32'h310C,     1, 1);
        cyc(19, 1, 1, 1, 4'd2,  32'h3104,     16'h0004, 26'h0,       32'h0,        2'b10, 2'b00, 32'h3118,     1'b1, 1'b1, 1'b1, 32'h310C,     2, 1);
        cyc(20, 1, 1, 0, 4'd2,  32'h3104,     16'h0004, 26'h0,       32'h0,        2'b10, 2'b00, 32'h3118,     1'b1, 1'b1, 1'b1, 32'h310C,     2, 1);
        cyc(21, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'h3118,     1'b1, 1'b1, 1'b0, 32'h8,        3, 1);
        cyc(22, 1, 1, 0, 4'd3,  32'h0,        16'h8000, 26'h0,       32'h0,        2'b00, 2'b00, 32'h311C,     1'b0, 1'b1, 1'b1, 32'h8,        3, 1);
        cyc(23, 1, 1, 0, 4'd0,  32'h0,        16'h0,    26'h0,       32'h0,        2'b00, 2'b00, 32'hFFFE0004, 1'b1, 1'b1, 1'b0, 32'h8,        4, 1);
        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
